// File: rtl/except_arbiter_seq.sv
// Purpose: registered exception/eret/interrupt arbiter for the memory stage, oldest lane wins.
// Latency: request appears one edge after capture; interrupts add INT_SYNC_STAGES edges of sync.
// Backpressure: a captured request is held frozen until flush_ack, then the arbiter re-arms.
module except_arbiter_seq #(
    parameter int          ISSUE_NUM       = 2,
    parameter int          INT_SYNC_STAGES = 2,
    parameter int          ERET_SHADOW     = 2,
    parameter logic [31:0] BEV_BASE        = 32'hbfc00200
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [ISSUE_NUM-1:0]                                  lane_valid,
    input  logic [ISSUE_NUM-1:0]                                  lane_ex_valid,
    input  logic [ISSUE_NUM-1:0]                                  lane_eret,
    input  logic [ISSUE_NUM-1:0]                                  lane_tlb_refill,
    input  logic [5*ISSUE_NUM-1:0]                                lane_exc_code,
    input  logic [32*ISSUE_NUM-1:0]                               lane_extra,
    input  logic [ISSUE_NUM-1:0]                                  lane_delayslot,
    input  logic [32*ISSUE_NUM-1:0]                               lane_pc,
    input  logic                                                  status_ie,
    input  logic                                                  status_exl,
    input  logic                                                  status_erl,
    input  logic                                                  status_bev,
    input  logic                                                  cause_iv,
    input  logic [19:0]                                           ebase,
    input  logic [31:0]                                           epc,
    input  logic [31:0]                                           error_epc,
    input  logic [7:0]                                            interrupt_req,
    input  logic                                                  flush_ack,
    output logic                                                  req_valid,
    output logic                                                  req_eret,
    output logic [4:0]                                            req_code,
    output logic [31:0]                                           req_extra,
    output logic [31:0]                                           req_pc,
    output logic                                                  req_delayslot,
    output logic [((ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1)-1:0]  req_lane,
    output logic [31:0]                                           req_vec,
    output logic                                                  int_masked
);

    // Lane index width; a single-lane build still carries a 1-bit index tied to 0.
    localparam int LANE_W = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1;
    // Shadow counter must hold ERET_SHADOW; a zero-length window still needs one bit.
    localparam int SH_W   = (ERET_SHADOW > 0) ? $clog2(ERET_SHADOW + 1) : 1;

    localparam logic [4:0]  CODE_INT  = 5'd0;
    localparam logic [4:0]  CODE_TLBL = 5'd2;
    localparam logic [4:0]  CODE_TLBS = 5'd3;
    localparam logic [11:0] OFF_REFILL = 12'h000;
    localparam logic [11:0] OFF_GEN    = 12'h180;
    localparam logic [11:0] OFF_IV     = 12'h200;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]      sync_q [INT_SYNC_STAGES];
    logic [7:0]      irq_s;
    logic [SH_W-1:0] shadow_cnt;

    // Oldest valid lane (interrupt attaches here) and oldest excepting/eret lane.
    logic              int_lane_found;
    logic [LANE_W-1:0] int_lane;
    logic [31:0]       int_pc;
    logic              cand_found;
    logic [LANE_W-1:0] cand_lane;
    logic [4:0]        cand_code;
    logic [31:0]       cand_extra;
    logic [31:0]       cand_pc;
    logic              cand_ds;
    logic              cand_eret;
    logic              cand_tlb;

    logic              int_take;

    // Captured fields presented to the request registers.
    logic              capture;
    logic [LANE_W-1:0] cap_lane;
    logic [4:0]        cap_code;
    logic [31:0]       cap_extra;
    logic [31:0]       cap_pc;
    logic              cap_ds;
    logic              cap_eret;
    logic              cap_tlb;
    logic [31:0]       cap_vec;
    logic [31:0]       vec_base;
    logic [11:0]       vec_off;

    // FSM handshake strobes.
    logic              load_req;
    logic              clear_req;
    logic              arm_shadow;

    // Interrupt lines come from another clock domain; plain shift chain, last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INT_SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h00;
            end
        end else begin
            sync_q[0] <= interrupt_req;
            for (int i = 1; i < INT_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign irq_s      = sync_q[INT_SYNC_STAGES-1];
    assign int_masked = (shadow_cnt != '0);

    // Priority scan: lane 0 is oldest, so the first hit in ascending order wins.
    always_comb begin
        int_lane_found = 1'b0;
        int_lane       = '0;
        int_pc         = '0;
        cand_found     = 1'b0;
        cand_lane      = '0;
        cand_code      = '0;
        cand_extra     = '0;
        cand_pc        = '0;
        cand_ds        = 1'b0;
        cand_eret      = 1'b0;
        cand_tlb       = 1'b0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            if (lane_valid[i] && !int_lane_found) begin
                int_lane_found = 1'b1;
                int_lane       = LANE_W'(i);
                int_pc         = lane_pc[32*i +: 32];
            end
            if (lane_valid[i] && (lane_ex_valid[i] || lane_eret[i]) && !cand_found) begin
                cand_found = 1'b1;
                cand_lane  = LANE_W'(i);
                cand_code  = lane_exc_code[5*i +: 5];
                cand_extra = lane_extra[32*i +: 32];
                cand_pc    = lane_pc[32*i +: 32];
                cand_ds    = lane_delayslot[i];
                // A real exception on an eret instruction is taken as an exception.
                cand_eret  = lane_eret[i] && !lane_ex_valid[i];
                cand_tlb   = lane_tlb_refill[i];
            end
        end
    end

    // Interrupt needs enabled, not already in a handler, outside the eret shadow,
    // and a valid instruction to attach its EPC to.
    assign int_take = status_ie && !status_exl && !status_erl && (irq_s != 8'h00)
                      && !int_masked && int_lane_found;

    // Select what would be captured this cycle; interrupt has priority over lane exceptions.
    always_comb begin
        capture   = 1'b0;
        cap_lane  = '0;
        cap_code  = '0;
        cap_extra = '0;
        cap_pc    = '0;
        cap_ds    = 1'b0;
        cap_eret  = 1'b0;
        cap_tlb   = 1'b0;
        if (int_take) begin
            capture  = 1'b1;
            cap_lane = int_lane;
            cap_code = CODE_INT;
            cap_pc   = int_pc;
        end else if (cand_found) begin
            capture   = 1'b1;
            cap_lane  = cand_lane;
            cap_code  = cand_code;
            cap_extra = cand_extra;
            cap_pc    = cand_pc;
            cap_ds    = cand_ds;
            cap_eret  = cand_eret;
            cap_tlb   = cand_tlb;
        end
    end

    // Redirect target from the CP0 state seen at capture time.
    always_comb begin
        vec_base = status_bev ? BEV_BASE : {ebase, 12'h000};
        vec_off  = OFF_GEN;
        if (!status_exl && cap_tlb && (cap_code == CODE_TLBL || cap_code == CODE_TLBS)) begin
            vec_off = OFF_REFILL;
        end else if (!status_exl && (cap_code == CODE_INT) && cause_iv) begin
            vec_off = OFF_IV;
        end
        if (cap_eret) begin
            cap_vec = status_erl ? error_epc : epc;
        end else begin
            cap_vec = vec_base + {20'h00000, vec_off};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture in IDLE, wait for the flush acknowledge in REQ.
    always_comb begin
        state_nxt  = state;
        load_req   = 1'b0;
        clear_req  = 1'b0;
        arm_shadow = 1'b0;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    load_req  = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_ack) begin
                    clear_req  = 1'b1;
                    arm_shadow = req_eret;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request registers: loaded once on capture and frozen until the flush is acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_valid     <= 1'b0;
            req_eret      <= 1'b0;
            req_code      <= '0;
            req_extra     <= '0;
            req_pc        <= '0;
            req_delayslot <= 1'b0;
            req_lane      <= '0;
            req_vec       <= '0;
        end else if (load_req) begin
            req_valid     <= 1'b1;
            req_eret      <= cap_eret;
            req_code      <= cap_code;
            req_extra     <= cap_extra;
            req_pc        <= cap_pc;
            req_delayslot <= cap_ds;
            req_lane      <= cap_lane;
            req_vec       <= cap_vec;
        end else if (clear_req) begin
            req_valid     <= 1'b0;
        end
    end

    // Shadow window after an acknowledged eret; counts down to zero in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_cnt <= '0;
        end else if (arm_shadow) begin
            shadow_cnt <= SH_W'(ERET_SHADOW);
        end else if (shadow_cnt != '0) begin
            shadow_cnt <= shadow_cnt - 1'b1;
        end
    end

endmodule

// File: doc/except_arbiter_seq.md
Name: except_arbiter_seq

Overview:
- Parametrised, registered successor to the combinational exception selector in the memory stage.
- Handles ISSUE_NUM lanes instead of two, and synchronises the external interrupt lines.
- Holds one exception/eret request stable until the pipeline acknowledges its flush.
- Masks interrupts for a programmable shadow window after each eret, so the handler-return instruction always makes progress.

Parameters:
ISSUE_NUM, 2, number of memory-stage lanes; lane 0 is oldest in program order.
INT_SYNC_STAGES, 2, flop stages on interrupt_req (min 1).
ERET_SHADOW, 2, cycles interrupts stay masked after an eret is acknowledged (0 = none).
BEV_BASE, 32'hbfc00200, exception base used when status_bev=1.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lane_valid  in  ISSUE_NUM  lane holds a valid instruction
lane_ex_valid  in  ISSUE_NUM  lane raised an exception
lane_eret  in  ISSUE_NUM  lane is an eret
lane_tlb_refill  in  ISSUE_NUM  exception is a TLB refill
lane_exc_code  in  5*ISSUE_NUM  exception code per lane
lane_extra  in  32*ISSUE_NUM  bad-vaddr/extra info per lane
lane_delayslot  in  ISSUE_NUM  lane is in a delay slot
lane_pc  in  32*ISSUE_NUM  lane PC
status_ie, status_exl, status_erl, status_bev, cause_iv  in  1 each  CP0 bits
ebase  in  20  EBase[31:12]
epc, error_epc  in  32 each  CP0 return addresses
interrupt_req  in  8  asynchronous-origin interrupt lines
flush_ack  in  1  pipeline has flushed and redirected fetch
req_valid  out  1  request pending
req_eret  out  1  request is an eret
req_code  out  5  exception code
req_extra  out  32  extra info
req_pc  out  32  faulting PC
req_delayslot  out  1  faulting instruction in delay slot
req_lane  out  $clog2(ISSUE_NUM) (min 1)  selected lane index
req_vec  out  32  redirect target
int_masked  out  1  shadow window active

Behaviour:
- Reset (sync, dominant over all other inputs): state IDLE; all outputs 0; sync chain 0; shadow counter 0.
  - Reset asserted in REQ drops req_valid at that edge; no ack is required.
- Interrupt sync: irq_s = last stage of an INT_SYNC_STAGES-deep chain on interrupt_req.
  - Input-to-visible latency is INT_SYNC_STAGES cycles.
- int_masked = (shadow counter != 0).
- int_take = status_ie & ~status_exl & ~status_erl & (irq_s != 0) & ~int_masked & (any lane_valid).
- Candidate lane c = lowest index i with lane_valid[i] & (lane_ex_valid[i] | lane_eret[i]). Younger lanes never win over an older one.
- State machine:
  - IDLE:
    - If int_take: capture code=0 (INT), extra=0, pc and lane of the lowest valid lane, delayslot=0, eret=0. Interrupt beats any lane exception.
    - Else if a candidate exists: capture lane c's fields, with eret=lane_eret[c] & ~lane_ex_valid[c]. An exception on an eret lane wins.
    - On capture, go to REQ. req_valid rises on the next edge (1-cycle latency).
  - REQ:
    - Outputs frozen; lane/CP0/interrupt inputs are not re-sampled.
    - On flush_ack: clear req_valid at that edge.
    - If req_eret, load the shadow counter with ERET_SHADOW; otherwise leave it unchanged. Go to IDLE.
    - A new capture is possible at the earliest one cycle later (no back-to-back within the ack cycle).
  - flush_ack in IDLE is ignored.
- Shadow counter decrements by 1 per cycle while nonzero, in any state, saturating at 0.
  - Lane exceptions and erets are still accepted during the shadow window; only interrupts are masked.
- req_vec, computed from CP0 values at capture time:
  - eret: error_epc if status_erl, else epc.
  - Otherwise offset = 12'h000 if ~exl & lane_tlb_refill & code in {TLBL=2, TLBS=3}; 12'h200 if ~exl & code==INT & cause_iv; else 12'h180.
  - base: BEV_BASE if status_bev, else {ebase,12'h000}. req_vec = base + offset.
- ISSUE_NUM=1 is legal; req_lane is then 1 bit, constant 0.

Test Plan:
- Lanes 1 and 2 of a 4-lane build raise codes 4 and 10, status_exl=0, status_bev=0, ebase=20'h80000 -> one cycle later req_valid=1, req_lane=1, req_code=4, req_vec=32'h80000180. Outputs hold while flush_ack=0 for 5 cycles.
- interrupt_req=8'h04 pulsed with ie=1, exl=0, erl=0, lane0 valid, INT_SYNC_STAGES=2 -> req_valid rises 3 cycles after the input (2 sync + 1 capture). Fields: code=0, delayslot=0, req_vec=32'hbfc00380 with bev=1, iv=0; 32'hbfc00400 with iv=1.
- eret on lane 0, status_erl=1, error_epc=32'h1234 -> req_eret=1, req_vec=32'h1234. After flush_ack with ERET_SHADOW=2, a pending interrupt stays ignored for exactly 2 cycles (int_masked=1) and is then taken.
- TLB refill on lane 0, code 2, exl=0, bev=0, ebase=20'h80000 -> req_vec=32'h80000000. Same stimulus with exl=1 -> 32'h80000180.
- rst asserted while in REQ -> req_valid=0 and state IDLE next edge. A flush_ack pulse in IDLE produces no change.
- Lane 0 raises an exception on an eret instruction -> req_eret=0, req_vec uses the 12'h180 offset, and the shadow counter is not loaded after ack.
